selector_pipe: RTL and testbench
================================

SELECTOR_PIPE -- requirements
Module: selector_pipe

Interface
REQ-001 The block SHALL take parameter WIDTH, default 5, as the bit width of each data choice.
REQ-002 The block SHALL take parameter NUM_IN, default 4, as the number of choices (legal range 2..32).
REQ-003 The block SHALL take parameter SEL_W, default 2, as the select width, with SEL_W >= clog2(NUM_IN).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_data  input  NUM_IN*WIDTH  packed choices; choice k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W  index of the choice to forward.
REQ-008 in_valid  input  1  producer offers in_data/in_sel this cycle.
REQ-009 in_ready  output  1  block accepts a transfer this cycle.
REQ-010 out_data  output  WIDTH  selected choice.
REQ-011 out_valid  output  1  out_data holds a valid result.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 flush  input  1  synchronous discard of all held results.
REQ-014 sel_err  output  1  sticky flag: an out-of-range select was accepted.
REQ-015 err_clr  input  1  synchronous clear of sel_err.

Function
REQ-016 An input transfer SHALL occur iff in_valid && in_ready at a rising edge; an output transfer SHALL occur iff out_valid && out_ready.
REQ-017 The block SHALL resolve the selected value at acceptance: in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN, else all-zero.
REQ-018 Storage SHALL be two entries: an output register (OR) driving out_data/out_valid, and a skid register (SR).
REQ-019 Latency SHALL be one cycle: a value accepted into an empty OR, or into an OR being drained the same edge, appears on out_data/out_valid in the next cycle.
REQ-020 in_ready SHALL equal !SR_valid and SHALL be driven from a register only, with no combinational path from out_ready or in_valid.
REQ-021 When OR is valid, OR is not drained, and an input transfer occurs, the value SHALL be written to SR.
REQ-022 When OR is drained and SR is valid, SR SHALL move to OR and SR SHALL become empty; an input transfer in the same edge is impossible (in_ready=0).
REQ-023 Order SHALL be preserved: values leave out_data in acceptance order, with none lost or duplicated.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-025 Sustained throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-026 flush=1 SHALL clear OR_valid and SR_valid at the edge; a transfer offered in the same cycle SHALL be dropped; in_ready SHALL be 1 the following cycle.
REQ-027 sel_err SHALL set at any edge where an accepted transfer has in_sel >= NUM_IN, including during flush.
REQ-028 err_clr SHALL clear sel_err, but a set in the same edge SHALL win.
REQ-029 Data registers SHALL NOT change when their valid bit is 0 and no load occurs.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force out_valid=0, SR_valid=0, in_ready=1, sel_err=0 and out_data=0.
REQ-031 Reset asserted mid-transfer SHALL discard all held values; after release, the first accepted input SHALL appear one cycle later.
REQ-032 Deassertion SHALL take effect at the first rising edge on which rst_n=1 is sampled.

Verification
REQ-033 With WIDTH=5 and NUM_IN=4, choices {3:0x1F, 2:0x0A, 1:0x15, 0:0x01}, sel=2, in_valid=1 and out_ready=1 -> the next cycle gives out_data=0x0A and out_valid=1; continuous sel sweep 0,1,2,3 gives 0x01,0x15,0x0A,0x1F on consecutive cycles.
REQ-034 out_ready=0 with three offered values A,B,C -> A is held in OR, B in SR, in_ready=0, and C is not accepted; then out_ready=1 -> out_data gives A, B, C in order with C accepted once in_ready returns.
REQ-035 NUM_IN=3 and SEL_W=2 with accepted sel=3 -> out_data=0 and sel_err=1 the next cycle; err_clr=1 together with another sel=3 leaves sel_err=1; err_clr=1 alone clears it.
REQ-036 OR and SR full, then flush=1 with in_valid=1 -> the next cycle gives out_valid=0 and in_ready=1, and the flushed and dropped values never appear.
REQ-037 rst_n pulsed low between clock edges while OR and SR are valid -> out_valid=0 and in_ready=1 with no clock edge needed; normal flow resumes with one-cycle latency.
REQ-038 Random in_valid/out_ready at 50% for 10k cycles, checked against a reference queue -> no loss, duplication or reordering, and out_data stable while stalled.

Source files
------------

// File: rtl/selector_pipe.sv
// Registered N-way selector with a two-entry (output + skid) buffer.
// The selected choice is resolved at acceptance; out-of-range selects forward zero and raise sel_err.
module selector_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err,
  input  logic                    err_clr
);

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side. in_ready is !sr_valid_q only, so it never depends on out_ready
  // or in_valid in the same cycle.
  localparam logic [SEL_W:0] NumInW = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0] or_data_q, or_data_d;
  logic             or_valid_q, or_valid_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic             sr_valid_q, sr_valid_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] sel_val;
  logic             sel_oob;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready  = !sr_valid_q;
  assign out_data  = or_data_q;
  assign out_valid = or_valid_q;
  assign sel_err   = sel_err_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = or_valid_q && out_ready;
  assign sel_oob  = {1'b0, in_sel} >= NumInW;

  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) sel_val = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    or_data_d  = or_data_q;
    or_valid_d = or_valid_q;
    sr_data_d  = sr_data_q;
    sr_valid_d = sr_valid_q;
    sel_err_d  = sel_err_q;

    if (flush) begin
      // Everything held or offered this cycle is discarded.
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (out_xfer || !or_valid_q) begin
      if (sr_valid_q) begin
        or_data_d  = sr_data_q;
        sr_valid_d = 1'b0;
      end else if (in_xfer) begin
        or_data_d  = sel_val;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      sr_data_d  = sel_val;
      sr_valid_d = 1'b1;
    end

    if (in_xfer && sel_oob) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_data_q  <= '0;
      or_valid_q <= 1'b0;
      sr_data_q  <= '0;
      sr_valid_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      or_data_q  <= or_data_d;
      or_valid_q <= or_valid_d;
      sr_data_q  <= sr_data_d;
      sr_valid_q <= sr_valid_d;
      sel_err_q  <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_selector_pipe.sv
// Directed and randomized checks of selector_pipe (4-way main instance, 3-way instance for range errors).
module tb_selector_pipe;

  logic        clk;
  logic        rst_n;
  logic [19:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        sel_err;
  logic        err_clr;

  logic [14:0] in_data3;
  logic [1:0]  in_sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [4:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic        flush3;
  logic        sel_err3;
  logic        err_clr3;

  int tests_run;
  int tests_failed;
  logic [4:0] exp_q[$];

  selector_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  selector_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .flush(flush3),
    .sel_err(sel_err3), .err_clr(err_clr3)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = {5'h1F, 5'h0A, 5'h15, 5'h01};
    in_sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
    in_data3 = {5'h0A, 5'h15, 5'h01};
    in_sel3 = 2'd0; in_valid3 = 1'b0; out_ready3 = 1'b1; flush3 = 1'b0; err_clr3 = 1'b0;
    #12;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (sel_err !== 1'b0) begin tests_failed++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
    tests_run++;
    if (out_data !== 5'h00) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    logic [4:0] exp_sweep[4];
    exp_sweep = '{5'h01, 5'h15, 5'h0A, 5'h1F};
    in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 5'h0A) begin
      tests_failed++; $display("FAIL sweep_first: got valid=%b data=%h expected valid=1 data=0a", out_valid, out_data);
    end
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp_sweep[i]) begin
        tests_failed++; $display("FAIL sweep_sel%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, exp_sweep[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL sweep_idle: got valid=%b expected 0", out_valid); end
    tests_run++;
    if (sel_err !== 1'b0) begin tests_failed++; $display("FAIL sweep_no_err: got %b expected 0", sel_err); end
  endtask

  task automatic test_backpressure();
    // A = sel1 (15), B = sel3 (1F), C = sel0 (01)
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 5'h15 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_a_in_or: got valid=%b data=%h rdy=%b expected 1 15 1", out_valid, out_data, in_ready);
    end
    in_sel = 2'd3;
    tick();
    tests_run++;
    if (out_data !== 5'h15 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_b_in_sr: got data=%h rdy=%b expected 15 0", out_data, in_ready);
    end
    in_sel = 2'd0;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 5'h15 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_stall_hold: got valid=%b data=%h rdy=%b expected 1 15 0", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 5'h1F || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_b_out: got valid=%b data=%h rdy=%b expected 1 1f 1", out_valid, out_data, in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 5'h01) begin
      tests_failed++; $display("FAIL bp_c_out: got valid=%b data=%h expected 1 01", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_sel_err();
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    tick();
    tests_run++;
    if (out_valid3 !== 1'b1 || out_data3 !== 5'h00 || sel_err3 !== 1'b1) begin
      tests_failed++; $display("FAIL err_set: got valid=%b data=%h err=%b expected 1 00 1", out_valid3, out_data3, sel_err3);
    end
    err_clr3 = 1'b1;
    tick();
    tests_run++;
    if (sel_err3 !== 1'b1) begin tests_failed++; $display("FAIL err_set_wins: got %b expected 1", sel_err3); end
    in_valid3 = 1'b0;
    tick();
    tests_run++;
    if (sel_err3 !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", sel_err3); end
    err_clr3 = 1'b0; in_valid3 = 1'b1; in_sel3 = 2'd2;
    tick();
    tests_run++;
    if (out_data3 !== 5'h0A || sel_err3 !== 1'b0) begin
      tests_failed++; $display("FAIL err_legal_sel: got data=%h err=%b expected 0a 0", out_data3, sel_err3);
    end
    in_valid3 = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    tick();
    in_sel = 2'd3;
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL flush_full: got rdy=%b valid=%b expected 0 1", in_ready, out_valid);
    end
    flush = 1'b1; in_sel = 2'd0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_clear: got valid=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    flush = 1'b0; out_ready = 1'b1; in_sel = 2'd2;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 5'h0A) begin
      tests_failed++; $display("FAIL flush_resume: got valid=%b data=%h expected 1 0a", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_ghost: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    tick();
    in_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 5'h00) begin
      tests_failed++; $display("FAIL async_reset: got valid=%b rdy=%b data=%h expected 0 1 00", out_valid, in_ready, out_data);
    end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 5'h0A) begin
      tests_failed++; $display("FAIL async_resume: got valid=%b data=%h expected 1 0a", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL async_drain: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic in_fire;
    logic out_fire;
    logic [4:0] exp_val;
    exp_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_data  = 20'($urandom);
      in_sel   = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      exp_val  = in_data[in_sel*5 +: 5];
      tick();
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) exp_q.push_back(exp_val);
      tests_run++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)) begin
        tests_failed++; $display("FAIL rand_occupancy cyc%0d: got valid=%b rdy=%b expected held=%0d", cyc, out_valid, in_ready, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        tests_run++;
        if (out_data !== exp_q[0]) begin
          tests_failed++; $display("FAIL rand_data cyc%0d: got %h expected %h", cyc, out_data, exp_q[0]);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_drain: got valid=%b expected 0", out_valid); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_sel_err();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
